stream_route_fifo: RTL and testbench

Parametrised successor to the bench's single-lane stream generator and fixed 5-way data mux. It buffers pushed bytes in a FIFO and drives AXI-Stream packets to one of NUM_CH destinations, for example the s_axis_data ports of I2C masters and slaves. The destination is locked per packet. Packets addressed to a non-existent channel are dropped and counted.

---
 rtl/stream_route_fifo.sv | 191 +++++++++++++++++++
 tb/tb_stream_route_fifo.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_route_fifo.sv
// Byte FIFO feeding NUM_CH AXI-Stream lanes with a per-packet locked destination.
// Define STREAM_ROUTE_AUTOLAST_EN to derive tlast from pkt_len instead of din_last.
module stream_route_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_last,
    input  logic              push,
    input  logic              op_en,
    input  logic [SEL_W-1:0]  sel,
    input  logic [15:0]       pkt_len,
    output logic [DATA_W-1:0] m_tdata,
    output logic [NUM_CH-1:0] m_tvalid,
    input  logic [NUM_CH-1:0] m_tready,
    output logic              m_tlast,
    output logic [CNT_W-1:0]  buff_count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StStream, StDrop} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;
    logic [DATA_W:0]    mem_q [DEPTH];

    logic [DATA_W:0]    head;
    logic               head_last;
    logic               empty_s, full_s;
    logic               push_ok, pop;
    logic               ready_sel;
    logic               sel_ok;

`ifdef STREAM_ROUTE_AUTOLAST_EN
    logic [15:0]        beat_q, beat_d;
    logic [15:0]        len_m1_q, len_m1_d;
    logic               unused_last;

    assign unused_last = head[DATA_W];
    assign head_last   = (beat_q == len_m1_q);
`else
    logic               unused_pkt_len;

    assign unused_pkt_len = ^pkt_len;
    assign head_last      = head[DATA_W];
`endif

    assign head    = mem_q[rd_ptr_q];
    assign empty_s = (count_q == '0);
    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign push_ok = push && !full_s;
    assign sel_ok  = (32'(sel) < NUM_CH);

    // m_tready of lanes other than the locked one has no effect.
    always_comb begin
        ready_sel = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (ch_q == SEL_W'(i)) begin
                ready_sel = m_tready[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        pop        = 1'b0;
        drop_cnt_d = drop_cnt_q;
`ifdef STREAM_ROUTE_AUTOLAST_EN
        beat_d     = beat_q;
        len_m1_d   = len_m1_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (op_en && !empty_s) begin
                    ch_d    = sel;
                    state_d = sel_ok ? StStream : StDrop;
`ifdef STREAM_ROUTE_AUTOLAST_EN
                    beat_d   = 16'd0;
                    len_m1_d = (pkt_len == 16'd0) ? 16'd0 : pkt_len - 16'd1;
`endif
                end
            end
            StStream: begin
                if (!empty_s && ready_sel) begin
                    pop = 1'b1;
                    if (head_last) begin
                        state_d = StIdle;
                    end
                end
            end
            StDrop: begin
                if (!empty_s) begin
                    pop = 1'b1;
                    if (drop_cnt_q != 8'hFF) begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                    if (head_last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef STREAM_ROUTE_AUTOLAST_EN
        if (pop) begin
            beat_d = beat_q + 16'd1;
        end
`endif
    end

    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = overflow_q | (push && full_s);
        count_d    = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        m_tvalid = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            m_tvalid[i] = (state_q == StStream) && !empty_s && (ch_q == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            ch_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
`ifdef STREAM_ROUTE_AUTOLAST_EN
            beat_q     <= 16'd0;
            len_m1_q   <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef STREAM_ROUTE_AUTOLAST_EN
            beat_q     <= beat_d;
            len_m1_q   <= len_m1_d;
`endif
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {din_last, din};
        end
    end

    assign m_tdata    = head[DATA_W-1:0];
    assign m_tlast    = head_last;
    assign buff_count = count_q;
    assign empty      = empty_s;
    assign full       = full_s;
    assign overflow   = overflow_q;
    assign busy       = (state_q != StIdle);
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_stream_route_fifo.sv
// Bench for stream_route_fifo: vector table, directed corner sequences and a random run
// checked cycle by cycle against a queue-based reference model.
module tb_stream_route_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int NUM_CH = 5;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] din;
    logic              din_last;
    logic              push;
    logic              op_en;
    logic [SEL_W-1:0]  sel;
    logic [15:0]       pkt_len;
    logic [DATA_W-1:0] m_tdata;
    logic [NUM_CH-1:0] m_tvalid;
    logic [NUM_CH-1:0] m_tready;
    logic              m_tlast;
    logic [CNT_W-1:0]  buff_count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              busy;
    logic [7:0]        drop_cnt;

    stream_route_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_last   (din_last),
        .push       (push),
        .op_en      (op_en),
        .sel        (sel),
        .pkt_len    (pkt_len),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .buff_count (buff_count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: packet-level view of the queue and the current destination.
    logic [DATA_W:0] mq[$];
    int   m_mode;   // 0 idle, 1 streaming to m_ch, 2 discarding
    int   m_ch;
    int   m_beat;
    int   m_lenm1;
    logic m_ovf;
    int   m_drop;

    int hs_cnt [NUM_CH];
    int last_hs;
    bit any_valid;

    typedef struct {
        logic              push;
        logic [7:0]        din;
        logic              dl;
        logic [NUM_CH-1:0] rdy;
        logic [NUM_CH-1:0] ev;
        logic [7:0]        ed;
        logic              el;
        logic [CNT_W-1:0]  ec;
        logic              eb;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic m_head_last();
`ifdef STREAM_ROUTE_AUTOLAST_EN
        return (m_beat == m_lenm1);
`else
        return mq[0][DATA_W];
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mode = 0;
        m_ch   = 0;
        m_beat = 0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic model_check();
        int sz;
        logic [NUM_CH-1:0] ev;
        sz = mq.size();
        ev = '0;
        if (m_mode == 1 && sz > 0) ev[m_ch] = 1'b1;
        chk("buff_count", 32'(buff_count), 32'(sz));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("m_tvalid", 32'(m_tvalid), 32'(ev));
        if (ev != '0) begin
            chk("m_tdata", 32'(m_tdata), 32'(mq[0][DATA_W-1:0]));
            chk("m_tlast", 32'(m_tlast), 32'(m_head_last()));
        end
    endtask

    task automatic model_step();
        int   sz;
        bit   pop;
        logic hl;
        if (!rst) begin
            model_reset();
            return;
        end
        sz  = mq.size();
        pop = 0;
        hl  = (sz > 0) ? m_head_last() : 1'b0;
        case (m_mode)
            0: if (op_en && sz > 0) begin
                m_ch    = int'(sel);
                m_mode  = (int'(sel) < NUM_CH) ? 1 : 2;
                m_beat  = 0;
                m_lenm1 = (pkt_len == 0) ? 0 : int'(pkt_len) - 1;
            end
            1: if (sz > 0 && m_tready[m_ch]) pop = 1;
            default: if (sz > 0) begin
                pop = 1;
                if (m_drop < 255) m_drop++;
            end
        endcase
        if (pop) begin
            m_beat++;
            if (hl) m_mode = 0;
            void'(mq.pop_front());
        end
        if (push && sz == DEPTH) m_ovf = 1'b1;
        if (push && sz < DEPTH) mq.push_back({din_last, din});
    endtask

    task automatic monitor();
        if (!rst) return;
        if (m_tvalid != '0) any_valid = 1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_tvalid[i] && m_tready[i]) begin
                hs_cnt[i]++;
                if (m_tlast) last_hs++;
            end
        end
    endtask

    task automatic drive(input logic p, input logic [7:0] d, input logic dl, input logic oe,
                         input logic [2:0] s, input logic [NUM_CH-1:0] r, input logic [15:0] pl,
                         input logic rs);
        push     = p;
        din      = d;
        din_last = dl;
        op_en    = oe;
        sel      = s;
        m_tready = r;
        pkt_len  = pl;
        rst      = rs;
    endtask

    // One clock: settle, check (table row tidx if >= 0, then model), clock, advance model.
    task automatic cyc(input int tidx);
        #3;
        if (tidx >= 0) begin
            chk("tbl_tvalid", 32'(m_tvalid), 32'(tbl[tidx].ev));
            chk("tbl_count", 32'(buff_count), 32'(tbl[tidx].ec));
            chk("tbl_busy", 32'(busy), 32'(tbl[tidx].eb));
            if (tbl[tidx].ev != '0) begin
                chk("tbl_tdata", 32'(m_tdata), 32'(tbl[tidx].ed));
                chk("tbl_tlast", 32'(m_tlast), 32'(tbl[tidx].el));
            end
        end
        model_check();
        monitor();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NUM_CH; i++) hs_cnt[i] = 0;
        last_hs   = 0;
        any_valid = 0;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, '0, 16'd0, 1'b0);
        cyc(-1);
        clear_stats();
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, '0, 16'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        clear_stats();

        // Single packet to lane 2, hand-derived per-cycle expectations.
        tbl[0] = '{1'b1, 8'hA1, 1'b0, 5'h04, 5'h00, 8'h00, 1'b0, 5'd0, 1'b0};
        tbl[1] = '{1'b1, 8'hA2, 1'b0, 5'h04, 5'h00, 8'h00, 1'b0, 5'd1, 1'b0};
        tbl[2] = '{1'b1, 8'hA3, 1'b1, 5'h04, 5'h04, 8'hA1, 1'b0, 5'd2, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 5'h04, 5'h04, 8'hA2, 1'b0, 5'd2, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 5'h04, 5'h04, 8'hA3, 1'b1, 5'd1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 5'h04, 5'h00, 8'h00, 1'b0, 5'd0, 1'b0};
        drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 5'h04, 16'd3, 1'b1);
        cyc(-1);
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].push, tbl[i].din, tbl[i].dl, 1'b1, 3'd2, tbl[i].rdy, 16'd3, 1'b1);
            cyc(i);
        end

        // Destination stays locked across a sel change; lane 1 ready toggles every cycle.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            logic [NUM_CH-1:0] r;
            r = (i % 2 == 1) ? 5'b01010 : 5'b01000;
            if (i < 4)
                drive(1'b1, 8'hB0 + 8'(i), i == 3, 1'b1, 3'd1, r, 16'd4, 1'b1);
            else if (i < 8)
                drive(1'b1, 8'hC0 + 8'(i), i == 7, 1'b1, 3'd3, r, 16'd4, 1'b1);
            else
                drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd3, r, 16'd4, 1'b1);
            cyc(-1);
        end
        chk("lane1_beats", 32'(hs_cnt[1]), 32'd4);
        chk("lane3_beats", 32'(hs_cnt[3]), 32'd4);

        // Fill past capacity with op_en low, then drain.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 8'h10 + 8'(i), i >= 15, 1'b0, 3'd0, '0, 16'd16, 1'b1);
            cyc(-1);
        end
        #3;
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(buff_count), 32'd16);
        chk("fill_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 5'h1F, 16'd16, 1'b1);
            cyc(-1);
        end
        chk("drain_beats", 32'(hs_cnt[0]), 32'd16);
        chk("drain_empty", 32'(empty), 32'd1);

        // Packet to a non-existent lane is discarded, the following one is delivered.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 3) drive(1'b1, 8'hD0 + 8'(i), i == 2, 1'b1, 3'd6, 5'h1F, 16'd3, 1'b1);
            else       drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd6, 5'h1F, 16'd3, 1'b1);
            cyc(-1);
        end
        chk("drop_cnt", 32'(drop_cnt), 32'd3);
        chk("drop_no_valid", 32'(any_valid), 32'd0);
        chk("drop_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i < 2) drive(1'b1, 8'hE0 + 8'(i), i == 1, 1'b1, 3'd4, 5'h1F, 16'd2, 1'b1);
            else       drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 5'h1F, 16'd2, 1'b1);
            cyc(-1);
        end
        chk("after_drop_beats", 32'(hs_cnt[4]), 32'd2);

        // Reset after two of four beats, then a fresh packet.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h50 + 8'(i), i == 3, 1'b1, 3'd0, 5'h01, 16'd4, 1'b1);
            cyc(-1);
        end
        chk("pre_reset_beats", 32'(hs_cnt[0]), 32'd2);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 5'h00, 16'd4, 1'b0);
        cyc(-1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 5'h01, 16'd3, 1'b1);
        #3;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_count", 32'(buff_count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        cyc(-1);
        clear_stats();
        for (int i = 0; i < 8; i++) begin
            if (i < 3) drive(1'b1, 8'h60 + 8'(i), i == 2, 1'b1, 3'd0, 5'h01, 16'd3, 1'b1);
            else       drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 5'h01, 16'd3, 1'b1);
            cyc(-1);
        end
        chk("post_reset_beats", 32'(hs_cnt[0]), 32'd3);
        chk("post_reset_lasts", 32'(last_hs), 32'd1);

`ifdef STREAM_ROUTE_AUTOLAST_EN
        // Length-derived tlast: pkt_len=2 splits four beats in two; pkt_len=0 means one.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(i < 4, 8'h70 + 8'(i), 1'b0, 1'b1, 3'd0, 5'h01, 16'd2, 1'b1);
            cyc(-1);
        end
        chk("auto_len2_lasts", 32'(last_hs), 32'd2);
        chk("auto_len2_beats", 32'(hs_cnt[0]), 32'd4);
        clear_stats();
        for (int i = 0; i < 12; i++) begin
            drive(i < 3, 8'h80 + 8'(i), 1'b0, 1'b1, 3'd0, 5'h01, 16'd0, 1'b1);
            cyc(-1);
        end
        chk("auto_len0_lasts", 32'(last_hs), 32'd3);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 99) < 80, 3'($urandom_range(0, 7)),
                  5'($urandom), 16'($urandom_range(0, 4)), $urandom_range(0, 299) != 0);
            cyc(-1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
